// File: rtl/udc_pkg.sv
// rtl/udc_pkg.sv - shared types, 7-segment table and load clamp for updown_counter_n
//
// Contents:
//   seg7_t       : one 7-segment digit pattern, bit 7 = dp (always 0), active-high
//   SEG7_TABLE   : hex nibble -> seg7_t pattern, index 0 first
//   clamp_load() : min(value, maxval) on 16-bit operands
package udc_pkg;

  typedef logic [7:0] seg7_t;

  localparam seg7_t SEG7_TABLE [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  // Load values above the modulus are pinned to the top count rather than
  // wrapped, so the counter never holds an out-of-range value.
  function automatic logic [15:0] clamp_load(input logic [15:0] value,
                                             input logic [15:0] maxval);
    return (value > maxval) ? maxval : value;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - hex nibble to 7-segment pattern decoder
//
// Ports:
//   nibble : input  [3:0]  hex digit value
//   seg    : output seg7_t pattern from SEG7_TABLE, dp bit is 0
module hex7seg
  import udc_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);

  assign seg = SEG7_TABLE[nibble];

endmodule

// File: rtl/updown_counter_n.sv
// rtl/updown_counter_n.sv - parametrised up/down counter with modulus, flags and 7-segment decode
//
// Parameters: NBITS (2..16), MAXVAL (1..2**NBITS-1), NDIGITS (hex digits on seg)
// Optional feature macro: UDC_SAT_EN (adds the sat input; without it the counter always wraps)
// Ports:
//   clk_2   : input  counter clock, rising edge
//   reset   : input  asynchronous, active-high reset
//   load    : input  synchronous load of data_in (clamped to MAXVAL), beats en
//   data_in : input  [NBITS-1:0] load value
//   en      : input  count enable
//   up      : input  1 = count up, 0 = count down
//   sat     : input  1 = saturate at bounds, 0 = wrap (only with UDC_SAT_EN)
//   count   : output [NBITS-1:0] current count
//   tc      : output registered terminal-count pulse, high for the cycle after a boundary step
//   ovf     : output sticky overflow/underflow, cleared by reset or load
//   seg     : output [8*NDIGITS-1:0] 7-segment patterns, digit 0 in bits [7:0]
module updown_counter_n
  import udc_pkg::*;
#(
  parameter int NBITS   = 8,
  parameter int MAXVAL  = 2**NBITS - 1,
  parameter int NDIGITS = (NBITS + 3) / 4
) (
  input  logic                 clk_2,
  input  logic                 reset,
  input  logic                 load,
  input  logic [NBITS-1:0]     data_in,
  input  logic                 en,
  input  logic                 up,
`ifdef UDC_SAT_EN
  input  logic                 sat,
`endif
  output logic [NBITS-1:0]     count,
  output logic                 tc,
  output logic                 ovf,
  output logic [8*NDIGITS-1:0] seg
);

  localparam logic [NBITS-1:0] MAX_C = NBITS'(MAXVAL);

  logic             sat_mode;
  logic             at_bound;
  logic [15:0]      load_clamped;

`ifdef UDC_SAT_EN
  assign sat_mode = sat;
`else
  assign sat_mode = 1'b0;
`endif

  // A step is a boundary event when it would leave [0, MAXVAL] in the
  // current direction; direction is taken from this cycle's up input.
  assign at_bound     = up ? (count == MAX_C) : (count == '0);
  assign load_clamped = clamp_load(16'(data_in), 16'(MAX_C));

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= NBITS'(load_clamped);
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (en) begin
      if (at_bound) begin
        tc  <= 1'b1;
        ovf <= 1'b1;
        // In saturate mode the count simply stays at the bound.
        if (!sat_mode) begin
          count <= up ? '0 : MAX_C;
        end
      end else begin
        tc    <= 1'b0;
        count <= up ? count + 1'b1 : count - 1'b1;
      end
    end else begin
      tc <= 1'b0;
    end
  end

  // Digits beyond the counter width read as zero.
  logic [4*NDIGITS-1:0] count_ext;
  assign count_ext = (4*NDIGITS)'(count);

  for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
    hex7seg u_hex7seg (
      .nibble (count_ext[4*i +: 4]),
      .seg    (seg[8*i +: 8])
    );
  end

endmodule
